// File: rtl/gray_seq_pkg.sv
// ---------------------------------------------------------------------------
// gray_seq_pkg
// Shared types and helpers for the Gray-code sequencer slice.
//   state_t   : controller FSM states (IDLE, RUN, PAUSE, DONE)
//   bin2gray  : binary -> reflected Gray conversion
//   gray2bin  : reflected Gray -> binary conversion
// Both helpers work on a GRAY_MAX_W-bit container. A narrower code that is
// zero-extended into the container converts to the correctly zero-extended
// result, so callers of any width up to GRAY_MAX_W cast in and truncate out.
// ---------------------------------------------------------------------------
package gray_seq_pkg;

    localparam int GRAY_MAX_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;

    function automatic logic [GRAY_MAX_W-1:0] bin2gray(input logic [GRAY_MAX_W-1:0] bin);
        return bin ^ (bin >> 1);
    endfunction

    // Each binary bit is the XOR of all Gray bits at and above it, so walk
    // down from the MSB carrying the running parity.
    function automatic logic [GRAY_MAX_W-1:0] gray2bin(input logic [GRAY_MAX_W-1:0] gray);
        logic [GRAY_MAX_W-1:0] bin;
        bin[GRAY_MAX_W-1] = gray[GRAY_MAX_W-1];
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            bin[i] = bin[i+1] ^ gray[i];
        end
        return bin;
    endfunction

endpackage

// File: rtl/gray_seq_ctrl_step_reg.sv
// ---------------------------------------------------------------------------
// gray_step_reg
// N-bit reflected-Gray register that advances by one code when adv is high.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset (code -> 0)
//   adv        in   advance one code at this edge
//   gray       out  current Gray code (registered)
//   wrap_pulse out  registered pulse, high the cycle the code wraps from
//                   1000..0 back to all-zero
// N must be at least 2 and at most gray_seq_pkg::GRAY_MAX_W.
// ---------------------------------------------------------------------------
module gray_step_reg
    import gray_seq_pkg::*;
#(
    parameter int N = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         adv,
    output logic [N-1:0] gray,
    output logic         wrap_pulse
);

    // The last code of a reflected-Gray cycle is MSB set, everything else clear.
    localparam logic [N-1:0] WRAP_CODE = {1'b1, {(N-1){1'b0}}};

    logic [N-1:0] gray_q;
    logic [N-1:0] gray_d;
    logic         wrap_q;
    logic         wrap_d;
    logic [N-1:0] binNext;

    // Next code is computed in binary at width N so the increment wraps
    // modulo 2^N before converting back; converting an unmasked carry would
    // corrupt the Gray MSB.
    always_comb begin
        gray_d  = gray_q;
        wrap_d  = 1'b0;
        binNext = N'(gray2bin(GRAY_MAX_W'(gray_q))) + N'(1);
        if (adv) begin
            gray_d = N'(bin2gray(GRAY_MAX_W'(binNext)));
            wrap_d = (gray_q == WRAP_CODE);
        end
    end

    // Code and wrap pulse registered together so wrap lines up with the
    // first cycle the all-zero code is visible.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gray_q <= '0;
            wrap_q <= 1'b0;
        end else begin
            gray_q <= gray_d;
            wrap_q <= wrap_d;
        end
    end

    assign gray       = gray_q;
    assign wrap_pulse = wrap_q;

endmodule

// File: rtl/gray_seq_ctrl.sv
// ---------------------------------------------------------------------------
// gray_seq_ctrl
// Command-driven sequencer owning an N-bit reflected-Gray counter. Commands
// arrive over a valid/ready handshake and run either one-shot (cmd_len
// steps) or continuously (free running, wrapping) until aborted. The counter
// value persists across commands and is cleared only by rst.
// Ports:
//   clk        in   clock
//   rst        in   asynchronous active-high reset
//   cmd_valid  in   command offered (accepted only in IDLE)
//   cmd_ready  out  high only in IDLE
//   cmd_len    in   one-shot step count (LEN_W bits)
//   cmd_cont   in   1 = continuous mode, cmd_len ignored
//   pause      in   level, holds the counter while high
//   abort      in   terminates the active command, beats pause/final step
//   gray_out   out  current Gray code (registered)
//   step_cnt   out  steps taken in the current command (saturating)
//   busy       out  high in RUN or PAUSE
//   done       out  one-cycle pulse when a command completes
//   wrap       out  one-cycle pulse when gray_out wraps to all-zero
//   gray_err   out  only with GRAY_SEQ_CHECK_EN: sticky integrity error
// Optional macro GRAY_SEQ_CHECK_EN adds gray_err and its checker.
// ---------------------------------------------------------------------------
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int N     = 5,
    parameter int LEN_W = N
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             cmd_cont,
    input  logic             pause,
    input  logic             abort,
    output logic [N-1:0]     gray_out,
    output logic [LEN_W-1:0] step_cnt,
    output logic             busy,
    output logic             done,
    output logic             wrap
`ifdef GRAY_SEQ_CHECK_EN
    ,
    output logic             gray_err
`endif
);

    localparam logic [LEN_W-1:0] STEP_MAX = '1;

    state_t           state_q;
    state_t           state_d;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] len_d;
    logic             cont_q;
    logic             cont_d;
    logic [LEN_W-1:0] step_cnt_q;
    logic [LEN_W-1:0] step_cnt_d;
    logic [LEN_W-1:0] stepInc;
    logic             adv;

    gray_step_reg #(
        .N(N)
    ) u_step_reg (
        .clk        (clk),
        .rst        (rst),
        .adv        (adv),
        .gray       (gray_out),
        .wrap_pulse (wrap)
    );

    // Next-state and advance decode. Abort is tested first so it wins over
    // both pause and the final one-shot step. A one-shot finishes on the same
    // edge that performs its last step, comparing the incremented count
    // against the latched length.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cont_d     = cont_q;
        step_cnt_d = step_cnt_q;
        adv        = 1'b0;
        stepInc    = step_cnt_q + LEN_W'(1);
        case (state_q)
            IDLE: begin
                if (cmd_valid) begin
                    len_d      = cmd_len;
                    cont_d     = cmd_cont;
                    step_cnt_d = '0;
                    if (!cmd_cont && (cmd_len == '0)) begin
                        state_d = DONE;
                    end else begin
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = DONE;
                end else if (pause) begin
                    state_d = PAUSE;
                end else begin
                    adv = 1'b1;
                    if (cont_q) begin
                        if (step_cnt_q != STEP_MAX) begin
                            step_cnt_d = stepInc;
                        end
                    end else begin
                        step_cnt_d = stepInc;
                        if (stepInc == len_q) begin
                            state_d = DONE;
                        end
                    end
                end
            end
            PAUSE: begin
                if (abort) begin
                    state_d = DONE;
                end else if (!pause) begin
                    state_d = RUN;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller state and latched command fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            len_q      <= '0;
            cont_q     <= 1'b0;
            step_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cont_q     <= cont_d;
            step_cnt_q <= step_cnt_d;
        end
    end

    assign cmd_ready = (state_q == IDLE);
    assign busy      = (state_q == RUN) || (state_q == PAUSE);
    assign done      = (state_q == DONE);
    assign step_cnt  = step_cnt_q;

`ifdef GRAY_SEQ_CHECK_EN
    logic [N-1:0] grayPrev_q;
    logic         advPrev_q;
    logic         grayErr_q;
    logic         grayErr_d;
    logic [N-1:0] grayDiff;

    // Compare each cycle's code with the previous one: a commanded advance
    // must flip exactly one bit, and any change without one is an error.
    always_comb begin
        grayDiff  = gray_out ^ grayPrev_q;
        grayErr_d = grayErr_q;
        if (advPrev_q) begin
            if ($countones(grayDiff) != 1) begin
                grayErr_d = 1'b1;
            end
        end else if (grayDiff != '0) begin
            grayErr_d = 1'b1;
        end
    end

    // History of the code and advance command, plus the sticky flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            grayPrev_q <= '0;
            advPrev_q  <= 1'b0;
            grayErr_q  <= 1'b0;
        end else begin
            grayPrev_q <= gray_out;
            advPrev_q  <= adv;
            grayErr_q  <= grayErr_d;
        end
    end

    assign gray_err = grayErr_q;
`endif

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gray_seq_ctrl
// Self-checking bench for gray_seq_ctrl (N=5). A behavioural model tracks the
// counter as a plain binary integer and the command as a remaining-step
// count; the Gray code is derived arithmetically. A compare process checks
// every output against the model on each falling edge, and directed
// sequences add hand-computed literal expectations before a random phase.
// ---------------------------------------------------------------------------
module tb_gray_seq_ctrl;

    localparam int N        = 5;
    localparam int LEN_W    = 5;
    localparam int CODES    = 1 << N;
    localparam int STEP_MAX = (1 << LEN_W) - 1;

    logic             clk;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len;
    logic             cmd_cont;
    logic             pause;
    logic             abort;
    logic [N-1:0]     gray_out;
    logic [LEN_W-1:0] step_cnt;
    logic             busy;
    logic             done;
    logic             wrap;
`ifdef GRAY_SEQ_CHECK_EN
    logic             gray_err;
`endif

    int  checks;
    int  passes;
    bit  checkEn;

    // Model state: binary counter value, steps, command progress flags.
    int  mBin;
    int  mSteps;
    int  mRemaining;
    bit  mActive;
    bit  mPaused;
    bit  mInDone;
    bit  mCont;
    bit  mWrap;

    gray_seq_ctrl #(
        .N     (N),
        .LEN_W (LEN_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .cmd_cont  (cmd_cont),
        .pause     (pause),
        .abort     (abort),
        .gray_out  (gray_out),
        .step_cnt  (step_cnt),
        .busy      (busy),
        .done      (done),
        .wrap      (wrap)
`ifdef GRAY_SEQ_CHECK_EN
        ,
        .gray_err  (gray_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    // Model update from the inputs seen at an edge, following the command
    // rules: a finished command spends one cycle reporting done, abort ends
    // anything active, and every unpaused active cycle advances once.
    task automatic updateModel();
        if (rst) begin
            mBin = 0; mSteps = 0; mRemaining = 0;
            mActive = 0; mPaused = 0; mInDone = 0; mCont = 0; mWrap = 0;
        end else begin
            mWrap = 0;
            if (mInDone) begin
                mInDone = 0;
            end else if (mActive) begin
                if (abort) begin
                    mActive = 0;
                    mPaused = 0;
                    mInDone = 1;
                end else if (mPaused) begin
                    if (!pause) mPaused = 0;
                end else if (pause) begin
                    mPaused = 1;
                end else begin
                    if (mBin == CODES - 1) mWrap = 1;
                    mBin = (mBin + 1) % CODES;
                    if (mCont) begin
                        if (mSteps < STEP_MAX) mSteps++;
                    end else begin
                        mSteps++;
                        mRemaining--;
                        if (mRemaining == 0) begin
                            mActive = 0;
                            mInDone = 1;
                        end
                    end
                end
            end else if (cmd_valid) begin
                mSteps     = 0;
                mCont      = cmd_cont;
                mRemaining = int'(cmd_len);
                if (!cmd_cont && cmd_len == '0) begin
                    mInDone = 1;
                end else begin
                    mActive = 1;
                    mPaused = 0;
                end
            end
        end
    endtask

    always @(posedge clk or posedge rst) updateModel();

    // Cycle-by-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("gray_out", int'(gray_out), mBin ^ (mBin >> 1));
            checkOutput("step_cnt", int'(step_cnt), mSteps);
            checkOutput("busy", int'(busy), int'(mActive));
            checkOutput("done", int'(done), int'(mInDone));
            checkOutput("wrap", int'(wrap), int'(mWrap));
            checkOutput("cmd_ready", int'(cmd_ready), int'(!mActive && !mInDone));
`ifdef GRAY_SEQ_CHECK_EN
            checkOutput("gray_err", int'(gray_err), 0);
`endif
        end
    end

    // Drive one set of inputs across exactly one rising edge; returns just
    // after the following falling edge so outputs reflect that edge.
    task automatic applyStimulus(input bit v, input int len, input bit c, input bit p, input bit a);
        cmd_valid = v;
        cmd_len   = LEN_W'(len);
        cmd_cont  = c;
        pause     = p;
        abort     = a;
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic resetDut();
        @(negedge clk);
        #2;
        rst = 1'b1;
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #1;
    endtask

    int wrapCount;
    int doneCount;

    initial begin
        checks = 0; passes = 0; checkEn = 0;
        rst = 1'b1;
        cmd_valid = 0; cmd_len = '0; cmd_cont = 0; pause = 0; abort = 0;
        #1;
        checkOutput("rst gray_out", int'(gray_out), 0);
        checkOutput("rst cmd_ready", int'(cmd_ready), 1);
        checkOutput("rst busy", int'(busy), 0);
        checkOutput("rst done", int'(done), 0);
        checkOutput("rst wrap", int'(wrap), 0);
        checkEn = 1;
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #1;

        // One-shot of 3 from 00000.
        applyStimulus(1, 3, 0, 0, 0);
        checkOutput("len3 busy after accept", int'(busy), 1);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("len3 step1", int'(gray_out), 5'b00001);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("len3 step2", int'(gray_out), 5'b00011);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("len3 step3", int'(gray_out), 5'b00010);
        checkOutput("len3 done", int'(done), 1);
        checkOutput("len3 step_cnt", int'(step_cnt), 3);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("len3 ready back", int'(cmd_ready), 1);
        checkOutput("len3 done cleared", int'(done), 0);

        // Zero-length one-shot: straight to DONE, code untouched.
        applyStimulus(1, 0, 0, 0, 0);
        checkOutput("len0 done", int'(done), 1);
        checkOutput("len0 gray hold", int'(gray_out), 5'b00010);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("len0 idle", int'(cmd_ready), 1);

        // Length 6 with a 2-cycle pause after 2 steps.
        resetDut();
        applyStimulus(1, 6, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("pause hold1", int'(gray_out), 5'b00011);
        applyStimulus(0, 0, 0, 1, 0);
        checkOutput("pause hold2", int'(gray_out), 5'b00011);
        checkOutput("pause busy", int'(busy), 1);
        doneCount = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 0, 0, 0);
            if (done) doneCount++;
        end
        checkOutput("pause final gray", int'(gray_out), 5'b00101);
        checkOutput("pause done count", doneCount, 1);

        // Continuous from 00000 for 32 advances, then abort.
        resetDut();
        applyStimulus(1, 0, 1, 0, 0);
        wrapCount = 0;
        for (int k = 1; k <= 32; k++) begin
            applyStimulus(0, 0, 0, 0, 0);
            if (wrap) wrapCount++;
            if (k == 31) checkOutput("cont last code", int'(gray_out), 5'b10000);
        end
        checkOutput("cont wrapped gray", int'(gray_out), 0);
        checkOutput("cont wrap pulse", int'(wrap), 1);
        checkOutput("cont wrap count", wrapCount, 1);
        checkOutput("cont step_cnt sat", int'(step_cnt), STEP_MAX);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("cont abort done", int'(done), 1);
        checkOutput("cont abort hold", int'(gray_out), 0);
        checkOutput("cont wrap cleared", int'(wrap), 0);

        // cmd_valid held while busy is ignored.
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(1, 4, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("held valid no early done", int'(done), 0);
        applyStimulus(0, 0, 0, 0, 0);
        checkOutput("held valid done", int'(done), 1);
        checkOutput("held valid steps", int'(step_cnt), 4);
        applyStimulus(0, 0, 0, 0, 0);

        // Abort and pause together: abort wins, no advance.
        applyStimulus(1, 5, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 1, 1);
        checkOutput("abort+pause done", int'(done), 1);
        checkOutput("abort+pause steps", int'(step_cnt), 1);
        applyStimulus(0, 0, 0, 0, 0);

        // Reset in the middle of a continuous run.
        applyStimulus(1, 0, 1, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        applyStimulus(0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst gray", int'(gray_out), 0);
        checkOutput("midrst step_cnt", int'(step_cnt), 0);
        checkOutput("midrst busy", int'(busy), 0);
        checkOutput("midrst done", int'(done), 0);
        checkOutput("midrst ready", int'(cmd_ready), 1);
        @(negedge clk);
        #2;
        rst = 1'b0;
        @(negedge clk);
        #1;

        // Random phase against the model.
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom % 100) < 30, int'($urandom_range(0, 12)),
                          ($urandom % 100) < 20, ($urandom % 100) < 15,
                          ($urandom % 100) < 4);
        end

        checkEn = 0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
